// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU function codes, pc_ctrl encodings and FSM states shared by ctrl_unit.
package ctrl_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_REL  = 2'b10;
    localparam logic [1:0] PC_ABS  = 2'b11;
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode decode into ALU controls and instruction class flags.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [3:0] i_op,
    output logic [3:0] o_alu_func,
    output logic       o_alu_in_sel,
    output logic       o_uses_alu,
    output logic       o_writes_reg,
    output logic       o_is_branch,
    output logic       o_is_jump,
    output logic       o_is_halt,
    output logic       o_is_illegal
);
    always_comb begin
        o_alu_func   = ALU_AND;
        o_alu_in_sel = 1'b0;
        o_uses_alu   = 1'b0;
        o_writes_reg = 1'b0;
        o_is_branch  = 1'b0;
        o_is_jump    = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        case (i_op)
            OP_NOP:  ;
            OP_ADD:  {o_alu_func, o_alu_in_sel, o_uses_alu, o_writes_reg} = {ALU_ADD, 3'b111};
            OP_SUB:  {o_alu_func, o_alu_in_sel, o_uses_alu, o_writes_reg} = {ALU_SUB, 3'b111};
            OP_AND:  {o_alu_func, o_alu_in_sel, o_uses_alu, o_writes_reg} = {ALU_AND, 3'b111};
            OP_OR:   {o_alu_func, o_alu_in_sel, o_uses_alu, o_writes_reg} = {ALU_OR,  3'b111};
            OP_SLT:  {o_alu_func, o_alu_in_sel, o_uses_alu, o_writes_reg} = {ALU_SLT, 3'b111};
            OP_ADDI: {o_alu_func, o_alu_in_sel, o_uses_alu, o_writes_reg} = {ALU_ADD, 3'b011};
            OP_BEQZ: {o_alu_func, o_alu_in_sel, o_uses_alu, o_is_branch}  = {ALU_SUB, 3'b111};
            OP_JMP:  o_is_jump = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: o_is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle FETCH/DECODE/EXEC/WB sequencer driving data_path control strobes.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes; otherwise they retire as NOP.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             alu_zero,
    output logic [3:0]       alu_func,
    output logic [7:0]       offset,
    output logic             alu_in_sel,
    output logic             en_ALUdec,
    output logic [1:0]       rd,
    output logic [1:0]       rs,
    output logic [3:0]       reg_en,
    output logic             w_en,
    output logic [1:0]       pc_ctrl,
    output logic             en_pc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif
    state_t           r_state, w_next;
    logic [15:0]      r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic             w_uses_alu, w_writes_reg, w_is_branch, w_is_jump, w_is_halt, w_is_illegal;
    ctrl_decoder u_dec (
        .i_op         (r_ir[15:12]),
        .o_alu_func   (alu_func),
        .o_alu_in_sel (alu_in_sel),
        .o_uses_alu   (w_uses_alu),
        .o_writes_reg (w_writes_reg),
        .o_is_branch  (w_is_branch),
        .o_is_jump    (w_is_jump),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    always_ff @(posedge clk or negedge rst)
        if (!rst)                                r_ir <= '0;
        else if (r_state == S_FETCH && instr_valid) r_ir <= instr;
    always_ff @(posedge clk or negedge rst)
        if (!rst)                r_cnt <= '0;
        else if (r_state == S_WB) r_cnt <= r_cnt + CNT_W'(1);
    // HALT and TRAP are absorbing: only reset leaves them
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = instr_valid ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_is_halt ? S_HALT : (TRAP_EN && w_is_illegal) ? S_TRAP : S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            default:  w_next = r_state;
        endcase
    end
    always_comb begin
        instr_ready = r_state == S_FETCH;
        halted      = r_state == S_HALT;
        illegal     = TRAP_EN && r_state == S_TRAP;
        en_ALUdec   = r_state == S_EXEC && w_uses_alu;
        en_pc       = r_state == S_WB;
        w_en        = r_state == S_WB && w_writes_reg;
        reg_en      = (r_state == S_WB && w_writes_reg) ? 4'b0001 << r_ir[11:10] : 4'b0000;
        pc_ctrl     = r_state != S_WB ? PC_HOLD :
                      w_is_jump ? PC_ABS :
                      (w_is_branch && alu_zero) ? PC_REL : PC_INC;
    end
    assign rd        = r_ir[11:10];
    assign rs        = r_ir[9:8];
    assign offset    = r_ir[7:0];
    assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: randomized instruction stream checked cycle-by-cycle against an opcode-table model.
module tb_ctrl_unit;
    localparam int CW = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   instr = '0;
    logic          instr_valid = 1'b0;
    logic          alu_zero = 1'b0;
    logic          instr_ready, alu_in_sel, en_ALUdec, w_en, en_pc, halted, illegal;
    logic [3:0]    alu_func, reg_en;
    logic [7:0]    offset;
    logic [1:0]    rd, rs, pc_ctrl;
    logic [CW-1:0] instr_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    ctrl_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .alu_zero(alu_zero), .alu_func(alu_func), .offset(offset), .alu_in_sel(alu_in_sel),
        .en_ALUdec(en_ALUdec), .rd(rd), .rs(rs), .reg_en(reg_en), .w_en(w_en), .pc_ctrl(pc_ctrl),
        .en_pc(en_pc), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0] func;
        logic       sel, alu, wr, br, jmp, halt, bad;
    } dec_t;
    function automatic dec_t ref_dec(input logic [3:0] op);
        dec_t d;
        d.alu  = op inside {[4'h1:4'h6], 4'h8};
        d.wr   = op inside {[4'h1:4'h6]};
        d.sel  = op inside {[4'h1:4'h5], 4'h8};
        d.br   = op == 4'h8;
        d.jmp  = op == 4'h9;
        d.halt = op == 4'hF;
        d.bad  = op inside {4'h7, [4'hA:4'hE]};
        d.func = (op == 4'h1 || op == 4'h6) ? 4'b0010 :
                 (op == 4'h2 || op == 4'h8) ? 4'b0110 :
                 op == 4'h4 ? 4'b0001 : op == 4'h5 ? 4'b0111 : 4'b0000;
        return d;
    endfunction
    function automatic logic [8:0] strb();
        return {en_ALUdec, w_en, reg_en, en_pc, pc_ctrl};
    endfunction
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_out", {alu_func, offset, alu_in_sel, en_ALUdec, rd, rs, reg_en, w_en,
                          pc_ctrl, en_pc, halted, illegal, instr_cnt}, 0);
        check("rst_ready", instr_ready, 1);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            instr = 16'($urandom);
            check("idle_ready", instr_ready, 1);
            check("idle_strb", strb(), 0);
            @(negedge clk);
        end
    endtask
    task automatic run(input logic [15:0] ins, input logic z);
        dec_t d;
        d = ref_dec(ins[15:12]);
        check("fetch_ready", instr_ready, 1);
        check("fetch_strb", strb(), 0);
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        check("dec_ready", instr_ready, 0);
        check("dec_strb", strb(), 0);
        check("fields", {rd, rs, offset}, ins[11:0]);
        @(negedge clk);
        if (d.halt || (TRAP && d.bad)) begin
            for (int i = 0; i < 3; i++) begin
                instr_valid = 1'b1;
                check("stop_flags", {halted, illegal, instr_ready}, d.halt ? 3'b100 : 3'b010);
                check("stop_strb", strb(), 0);
                check("stop_cnt", instr_cnt, exp_cnt);
                @(negedge clk);
            end
            instr_valid = 1'b0;
            do_reset();
            return;
        end
        check("exec_alu", en_ALUdec, d.alu);
        check("exec_sel", alu_in_sel, d.sel);
        check("exec_func", alu_func, d.func);
        check("exec_quiet", {w_en, reg_en, en_pc, pc_ctrl}, 0);
        @(negedge clk);
        alu_zero = z;
        #1;
        check("wb_wen", w_en, d.wr);
        check("wb_regen", reg_en, d.wr ? 4'b0001 << ins[11:10] : 4'b0000);
        check("wb_enpc", en_pc, 1);
        check("wb_alu", en_ALUdec, 0);
        check("wb_pc", pc_ctrl, d.jmp ? 2'b11 : (d.br && z) ? 2'b10 : 2'b01);
        check("wb_func", alu_func, d.func);
        check("wb_flags", {halted, illegal}, 0);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        @(negedge clk);
        alu_zero = 1'($urandom);
        check("cnt", instr_cnt, exp_cnt);
    endtask
    initial begin
        @(negedge clk);
        do_reset();
        idle(2);
        run(16'h1400, 1'b0);
        run(16'h6409, 1'b1);
        run(16'h81FC, 1'b1);
        run(16'h81FC, 1'b0);
        run(16'h9020, 1'b1);
        run(16'hA000, 1'b0);
        run(16'h1400, 1'b0);
        run(16'hF000, 1'b0);
        for (int i = 0; i < 18; i++) run({4'h0, 12'($urandom)}, 1'($urandom));
        instr = 16'h1400;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check("abort_exec", en_ALUdec, 1);
        do_reset();
        check("abort_strb", strb(), 0);
        @(negedge clk);
        check("abort_ready", instr_ready, 1);
        check("abort_strb2", strb(), 0);
        check("abort_cnt", instr_cnt, 0);
        for (int i = 0; i < 160; i++) begin
            logic [3:0] op;
            op = 4'($urandom);
            if (op == 4'hF && $urandom_range(3) != 0) op = 4'h1;
            run({op, 12'($urandom)}, 1'($urandom));
            idle($urandom_range(2));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Multi-cycle control unit for the 16-bit CPU. It accepts one 16-bit instruction at a time from instruction memory, decodes it, and sequences the control strobes that `data_path` consumes. The strobes are `alu_func`, `offset`, `alu_in_sel`, `en_ALUdec`, `rd`, `rs`, `reg_en`, `pc_ctrl`, `en_pc` and `w_en`. It sits between instruction fetch (addressed by `data_path.pc_out`) and `data_path`, and is the driving end of that control interface.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction word from instruction memory.
- `instr_valid`  in  1  `instr` is valid this cycle.
- `instr_ready`  out  1  control unit can accept an instruction (FETCH state only).
- `alu_zero`  in  1  zero flag registered by `data_path` on the `en_ALUdec` edge.
- `alu_func`  out  4  ALU operation code.
- `offset`  out  8  immediate / branch offset, `IR[7:0]`.
- `alu_in_sel`  out  1  0 = immediate operand B, 1 = register operand B.
- `en_ALUdec`  out  1  ALU result/flag register enable, one-cycle pulse.
- `rd`  out  2  destination / operand-B register index, `IR[11:10]`.
- `rs`  out  2  source / operand-A register index, `IR[9:8]`.
- `reg_en`  out  4  one-hot register write enable.
- `w_en`  out  1  register-file write strobe.
- `pc_ctrl`  out  2  next-PC select: 00 hold, 01 +1, 10 PC + sign-extended `offset`, 11 zero-extended `offset`.
- `en_pc`  out  1  PC update strobe, one-cycle pulse.
- `halted`  out  1  HALT executed.
- `illegal`  out  1  illegal opcode trapped (only with the macro; otherwise tied 0).
- `instr_cnt`  out  `CNT_W`  retired instruction count.

## Operation
- Instruction format: `[15:12]` opcode, `[11:10]` rd, `[9:8]` rs, `[7:0]` offset.
- Instruction register `IR` is loaded on the accept edge.
- `rd`, `rs` and `offset` are driven from `IR` in every state.
- Opcodes and their ALU codes / effects:
  - 0x0 NOP.
  - 0x1 ADD, `alu_func` 0010.
  - 0x2 SUB, 0110.
  - 0x3 AND, 0000.
  - 0x4 OR, 0001.
  - 0x5 SLT, 0111.
  - 0x6 ADDI, 0010 with `alu_in_sel`=0.
  - 0x8 BEQZ: SUB rd,rs; branch relative if zero.
  - 0x9 JMP: absolute jump.
  - 0xF HALT.
  - All others are illegal.
- `alu_in_sel` is 1 for opcodes 0x1–0x5 and 0x8, and 0 otherwise.
- FSM states: FETCH, DECODE, EXEC, WB, HALT, TRAP.
  - FETCH: `instr_ready`=1. On `instr_valid`, load `IR` and go to DECODE.
  - DECODE: one cycle. HALT goes to the HALT state. Illegal goes to TRAP (macro) or is handled as NOP. Everything else goes to EXEC.
  - EXEC: `en_ALUdec`=1 for opcodes 0x1–0x6 and 0x8, 0 for NOP/JMP. Next state is WB.
  - WB: `en_pc`=1.
    - ALU ops and ADDI: `w_en`=1, `reg_en`=1<<rd, `pc_ctrl`=01.
    - BEQZ: `pc_ctrl`=10 if `alu_zero`, else 01; no write.
    - JMP: `pc_ctrl`=11.
    - NOP: `pc_ctrl`=01.
    - `instr_cnt` increments; next state is FETCH.
  - HALT: `halted`=1, all strobes 0, `instr_ready`=0. Exit only by reset.
- `instr_cnt` wraps modulo 2^`CNT_W`. HALT and trapped instructions are not counted.
- Outputs are decoded only from the state register and `IR`. There is no combinational path from inputs to outputs, except `pc_ctrl` in WB, which depends on `alu_zero`.

## Timing
- Reset (`rst`=0, asynchronous):
  - State goes to FETCH and `IR` to 0.
  - All outputs go to 0 immediately, except `instr_ready`, which goes to 1.
  - `instr_cnt` goes to 0.
  - Reset applied mid-instruction aborts that instruction with no write and no PC update.
- Latency: accept edge N; DECODE at N+1, EXEC at N+2, WB at N+3, FETCH (ready) at N+4. Four cycles per instruction.
- `en_ALUdec`, `w_en`, `reg_en` and `en_pc` are high for exactly one cycle per instruction. They are never high in FETCH, DECODE, HALT or TRAP.
- `alu_zero` is sampled in WB and reflects the EXEC-edge result.
- While `instr_valid` is low in FETCH, the unit stays in FETCH and all strobes stay 0.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode goes DECODE→TRAP. In TRAP, `illegal`=1, `instr_ready`=0, all strobes 0, until reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined: an illegal opcode executes as NOP (`pc_ctrl`=01, counted), and `illegal` is tied 0.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - ALU function codes (shared with the `data_path` ALU);
  - `pc_ctrl` encodings;
  - the FSM state encoding.
- Sub-module `ctrl_decoder`: combinational opcode → {`alu_func`, `alu_in_sel`, uses_alu, writes_reg, is_branch, is_jump, is_halt, is_illegal}.
- The FSM and counter live in `ctrl_unit`.

## Test plan
- ADD `16'h1400`, valid in FETCH:
  - WB at +3: `reg_en`=0010, `w_en`=1, `alu_func`=0010, `alu_in_sel`=1, `en_pc`=1, `pc_ctrl`=01.
  - `instr_cnt` becomes 1.
- ADDI `16'h6409`:
  - EXEC: `en_ALUdec`=1, `alu_in_sel`=0, `offset`=8'h09.
  - WB: `reg_en`=0010.
- BEQZ `16'h81FC`:
  - `alu_zero`=1 in WB → `pc_ctrl`=10, `offset`=8'hFC, `w_en`=0.
  - `alu_zero`=0 → `pc_ctrl`=01.
- JMP `16'h9020`:
  - EXEC: `en_ALUdec`=0.
  - WB: `pc_ctrl`=11, `en_pc`=1.
- HALT `16'hF000`:
  - `halted`=1 from +2.
  - `instr_ready`=0 thereafter; `en_pc` never pulses; `instr_cnt` unchanged.
- `16'hA000` with the macro → `illegal`=1, stuck. Without the macro → NOP, counted.
- `rst` low during EXEC of ADD → no `w_en`, no `en_pc`, FETCH with `instr_ready`=1.
